// File: rtl/seq_muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the sequential multiply/divide unit.
//   op_t      : operation encoding carried on the 2-bit op port
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the iteration counter for an N-bit datapath
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // The counter must be able to hold N, so it is sized for N+1 values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_twos_mag.sv
// twos_mag: combinational two's-complement conditional negate.
// On the operand side it turns a signed N-bit value into its magnitude
// (neg = sign bit); the magnitude of the most negative value is 2^(N-1),
// which still fits the N-bit unsigned result. On the result side it
// applies the product sign to the 2N-bit unsigned product.
//   val : W-bit input value
//   neg : 1 = output the two's-complement negation of val
//   mag : W-bit result
module twos_mag #(
  parameter int W = 4
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] mag
);

  assign mag = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle N-bit unsigned/signed multiplier and unsigned
// divider, one shift-add / shift-subtract step per clock.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, taken only when not busy (IDLE or DONE)
//   op           : 00 mulu, 01 muls, 10 divu, 11 reserved
//   A, B         : operands, sampled with an accepted start
//   Y            : 2N-bit result; div returns {remainder, quotient}
//   busy         : high while iterating
//   done         : one-cycle pulse, Y valid
//   div_by_zero  : divide with B=0 (quotient all ones, remainder A)
//   op_err       : reserved op (Y=0)
//   fsm_state    : controller state, for observation only
//
// Handshake: start is sampled on a rising edge only while busy is low; an
// accepted start latches A, B and op. done pulses for one cycle when Y
// holds the new result; holding start high through DONE chains the next op.
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Y,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           op_err,
  output state_t         fsm_state
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  op_t            op_r;
  logic [N-1:0]   opnd_r;   // multiplicand magnitude or divisor
  logic [2*N-1:0] acc;      // mul: {partial product, multiplier}; div: {rem, dividend/quotient}
  logic           neg_r;    // signed product must be negated

  op_t          op_in;
  logic         muls_in;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;

  assign op_in   = op_t'(op);
  assign muls_in = (op_in == OP_MULS);

  twos_mag #(.W(N)) u_mag_a (.val(A), .neg(muls_in & A[N-1]), .mag(mag_a));
  twos_mag #(.W(N)) u_mag_b (.val(B), .neg(muls_in & B[N-1]), .mag(mag_b));

  // Multiply step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right by one.
  // The carry out of the add becomes the new MSB.
  logic [N:0]     add_sum;
  logic [2*N-1:0] mul_next;
  assign add_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opnd_r : {N{1'b0}})};
  assign mul_next = {add_sum, acc[N-1:1]};

  // Restoring divide step: shift the next dividend bit into the (N+1)-bit
  // partial remainder, subtract when it fits, shift the quotient bit in.
  logic [N:0]     trial;
  logic [N:0]     diff;
  logic           fits;
  logic [2*N-1:0] div_next;
  assign trial    = {acc[2*N-1:N], acc[N-1]};
  assign diff     = trial - {1'b0, opnd_r};
  assign fits     = (trial >= {1'b0, opnd_r});
  assign div_next = fits ? {diff[N-1:0], acc[N-2:0], 1'b1}
                         : {trial[N-1:0], acc[N-2:0], 1'b0};

  logic [2*N-1:0] step_next;
  logic [2*N-1:0] y_fin;
  assign step_next = (op_r == OP_DIVU) ? div_next : mul_next;

  twos_mag #(.W(2*N)) u_neg_y (.val(step_next), .neg(neg_r), .mag(y_fin));

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= OP_MULU;
      opnd_r      <= '0;
      acc         <= '0;
      neg_r       <= 1'b0;
      Y           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_r        <= op_in;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            op_err      <= 1'b0;
            neg_r       <= muls_in & (A[N-1] ^ B[N-1]);
            if (op_in == OP_RSVD) begin
              Y      <= '0;
              op_err <= 1'b1;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end else if ((op_in == OP_DIVU) && (B == '0)) begin
              Y           <= {A, {N{1'b1}}};
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              // Divide uses raw operands; for unsigned mul the magnitudes
              // equal the raw operands anyway.
              acc    <= {{N{1'b0}}, (op_in == OP_DIVU) ? A : mag_b};
              opnd_r <= (op_in == OP_DIVU) ? B : mag_a;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            Y     <= y_fin;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: self-checking bench for seq_muldiv (N=4). Directed cases,
// start-while-busy, back-to-back, mid-operation reset and random ops are
// compared against an arithmetic reference model via an expected queue.
module tb_seq_muldiv;
  import muldiv_pkg::*;

  localparam int N = 4;
  localparam int W = 2 * N;
  localparam int TMO = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         op_err;
  state_t       fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W+1:0] exp_q[$];      // {op_err, div_by_zero, Y}
  logic [W-1:0] last_y = '0;

  seq_muldiv #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .Y(Y), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .op_err(op_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    int sa;
    int sb;
    logic [W-1:0] y;
    logic dz;
    logic oe;
    dz = 1'b0;
    oe = 1'b0;
    y  = '0;
    case (o)
      2'b00: y = W'(int'(a) * int'(b));
      2'b01: begin
        sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
        y  = W'(sa * sb);
      end
      2'b10: begin
        if (b == 0) begin
          dz = 1'b1;
          y  = {a, {N{1'b1}}};
        end else begin
          y = {N'(a % b), N'(a / b)};
        end
      end
      default: oe = 1'b1;
    endcase
    return {oe, dz, y};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_y", 64'(Y), 64'(e[W-1:0]));
        check("result_dz", 64'(div_by_zero), 64'(e[W]));
        check("result_oe", 64'(op_err), 64'(e[W+1]));
        last_y = e[W-1:0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one op from a ready state; lat = edges after the start edge until
  // done is seen, nbusy = sampled cycles with busy high.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done && lat < TMO) begin
      if (busy) begin
        nbusy++;
        check("y_holds_while_busy", 64'(Y), 64'(last_y));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check("timeout_done", 64'd0, 64'd1);
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [W-1:0] y_exp, input int lat_exp);
    int lat;
    int nb;
    run_op(o, a, b, lat, nb);
    check({tag, "_y"}, 64'(Y), 64'(y_exp));
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(lat_exp));
  endtask

  // Wait (on falling edges) for the next done pulse; returns its cycle.
  task automatic wait_done_neg(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout_done_b2b", 64'd0, 64'd1);
    c = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int nb;
    int c_prev;
    int c_now;
    logic [1:0]   ro;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] bb_a[4];
    logic [N-1:0] bb_b[4];

    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", 64'(Y), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    check("reset_oe", 64'(op_err), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    directed("mulu_15x15", 2'b00, 4'd15, 4'd15, 8'd225, N);
    directed("mulu_0x0",   2'b00, 4'd0,  4'd0,  8'd0,   N);
    directed("muls_m8x7",  2'b01, 4'h8,  4'd7,  8'hC8,  N);
    directed("muls_m1xm1", 2'b01, 4'hF,  4'hF,  8'h01,  N);
    directed("muls_m8xm8", 2'b01, 4'h8,  4'h8,  8'h40,  N);
    directed("divu_13_4",  2'b10, 4'd13, 4'd4,  8'h13,  N);
    directed("divu_15_1",  2'b10, 4'd15, 4'd1,  8'h0F,  N);
    directed("divu_3_7",   2'b10, 4'd3,  4'd7,  8'h30,  N);
    directed("divu_9_0",   2'b10, 4'd9,  4'd0,  8'h9F,  0);
    check("div0_flag", 64'(div_by_zero), 64'd1);
    directed("rsvd_op",    2'b11, 4'd5,  4'd6,  8'h00,  0);
    check("rsvd_flag", 64'(op_err), 64'd1);
    directed("mulu_3x3",   2'b00, 4'd3,  4'd3,  8'd9,   N);
    check("flags_clear_dz", 64'(div_by_zero), 64'd0);
    check("flags_clear_oe", 64'(op_err), 64'd0);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 4'd5; B = 4'd3;
    exp_q.push_back(model(2'b00, 4'd5, 4'd3));
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 4'd15; B = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done_neg(c_now);
    check("ignore_start_y", 64'(Y), 64'd15);

    // back-to-back with start held high
    bb_a[0] = 4'd7;  bb_b[0] = 4'd9;
    bb_a[1] = 4'd12; bb_b[1] = 4'd11;
    bb_a[2] = 4'd2;  bb_b[2] = 4'd13;
    bb_a[3] = 4'd14; bb_b[3] = 4'd6;
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = bb_a[0]; B = bb_b[0];
    exp_q.push_back(model(2'b00, bb_a[0], bb_b[0]));
    c_prev = -1;
    for (int k = 1; k <= 4; k++) begin
      wait_done_neg(c_now);
      if (c_prev >= 0) check("b2b_period", 64'(c_now - c_prev), 64'(N + 1));
      c_prev = c_now;
      if (k < 4) begin
        A = bb_a[k]; B = bb_b[k];
        exp_q.push_back(model(2'b00, bb_a[k], bb_b[k]));
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1 check("b2b_idle_done", 64'(done), 64'd0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 4'd9; B = 4'd9;
    exp_q.push_back(model(2'b00, 4'd9, 4'd9));
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_y", 64'(Y), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    exp_q.delete();
    last_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_reset", 64'(done), 64'd0);
    end
    directed("post_reset_6x5", 2'b00, 4'd6, 4'd5, 8'd30, N);

    // randomized ops
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = N'($urandom_range(0, 15));
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 15));
      run_op(ro, ra, rb, lat, nb);
      check("rand_lat", 64'(lat), 64'(((ro == 2'b11) || (ro == 2'b10 && rb == 0)) ? 0 : N));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
